// File: rtl/radio_pkg.sv
// Fixed-point constants, quantization helpers and the demodulator state type
// shared across the radio datapath.
package radio_pkg;

    localparam int BITS_DEF = 10;
    localparam int GAIN_DEF = 758;
    localparam int QUAD1    = 804;
    localparam int QUAD3    = 2412;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_SUM,
        ST_PREP,
        ST_DIV,
        ST_ANGLE,
        ST_OUT
    } demod_state_t;

    // Floor division by 2^bits (arithmetic shift keeps the sign).
    function automatic logic signed [63:0] deq(input logic signed [63:0] x, input int bits);
        return x >>> bits;
    endfunction

    function automatic logic signed [63:0] quant(input logic signed [63:0] x, input int bits);
        return x <<< bits;
    endfunction

endpackage

// File: rtl/fm_demod_if.sv
// Sample-in / demod-out signal bundle of the FM discriminator.
interface fm_demod_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] Iin;
    logic signed [DATA_WIDTH-1:0] Qin;
    logic                         newDataAvailible;
    logic signed [DATA_WIDTH-1:0] Dout;
    logic                         Done;
    logic                         Busy;
    logic                         Overrun;

    modport master (
        output Iin, Qin, newDataAvailible,
        input  Dout, Done, Busy, Overrun
    );

    modport slave (
        input  Iin, Qin, newDataAvailible,
        output Dout, Done, Busy, Overrun
    );
endinterface

// File: rtl/div_seq.sv
// Signed restoring divider, one quotient bit per clock on operand magnitudes;
// quotient truncates toward zero. Caller guarantees a non-zero divisor.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic                    done,
    output logic signed [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        // Dividend magnitude shifts out of quo_q's MSB as quotient bits enter its LSB.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (start) begin
            busy_d = 1'b1;
            neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            quo_d  = mag(dividend);
            dvs_d  = mag(divisor);
            rem_d  = '0;
            cnt_d  = CW'(WIDTH - 1);
        end else if (busy_q) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done     = done_q;
    assign quotient = neg_q ? -$signed(quo_q) : $signed(quo_q);

endmodule

// File: rtl/fm_demod.sv
// Quadrature FM discriminator: conjugate product with the previous sample,
// qarctan phase estimate via the sequential divider, then gain scaling.
module fm_demod
    import radio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = BITS_DEF,
    parameter int GAIN       = GAIN_DEF
) (
    input  logic      clock,
    input  logic      reset,
    fm_demod_if.slave bus
);
    typedef logic signed [DATA_WIDTH-1:0] sdat_t;

    demod_state_t state_q, state_d;
    sdat_t ic_q, ic_d, qc_q, qc_d, ip_q, ip_d, qp_q, qp_d;
    sdat_t hist_i_q, hist_i_d, hist_q_q, hist_q_d;
    sdat_t p_rr_q, p_rr_d, p_qq_q, p_qq_d, p_iq_q, p_iq_d, p_qi_q, p_qi_d;
    sdat_t r_q, r_d, i_q, i_d;
    sdat_t angle_q, angle_d, dout_q, dout_d;
    logic  x_neg_q, x_neg_d, y_neg_q, y_neg_d;
    logic  done_q, done_d, overrun_q, overrun_d;

    sdat_t ay, num, den, quot, base, mag_a;
    logic  div_start, div_done;

    function automatic sdat_t deq_mul(input sdat_t a, input sdat_t b);
        return DATA_WIDTH'(deq(64'(a) * 64'(b), BITS));
    endfunction

    function automatic sdat_t deq_nmul(input sdat_t a, input sdat_t b);
        return DATA_WIDTH'(deq(-(64'(a) * 64'(b)), BITS));
    endfunction

    always_comb begin
        ay = ((i_q < 0) ? -i_q : i_q) + sdat_t'(1);
        if (r_q >= 0) begin
            num = DATA_WIDTH'(quant(64'(r_q - ay), BITS));
            den = r_q + ay;
        end else begin
            num = DATA_WIDTH'(quant(64'(r_q + ay), BITS));
            den = ay - r_q;
        end
    end

    div_seq #(.WIDTH(DATA_WIDTH)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (num),
        .divisor  (den),
        .done     (div_done),
        .quotient (quot)
    );

    always_comb begin
        base  = x_neg_q ? sdat_t'(QUAD3) : sdat_t'(QUAD1);
        mag_a = base - DATA_WIDTH'(deq(64'(QUAD1) * 64'(quot), BITS));
    end

    always_comb begin
        state_d   = state_q;
        ic_d      = ic_q;
        qc_d      = qc_q;
        ip_d      = ip_q;
        qp_d      = qp_q;
        hist_i_d  = hist_i_q;
        hist_q_d  = hist_q_q;
        p_rr_d    = p_rr_q;
        p_qq_d    = p_qq_q;
        p_iq_d    = p_iq_q;
        p_qi_d    = p_qi_q;
        r_d       = r_q;
        i_d       = i_q;
        x_neg_d   = x_neg_q;
        y_neg_d   = y_neg_q;
        angle_d   = angle_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        // Only IDLE accepts; a strobe anywhere else is dropped and flagged.
        overrun_d = overrun_q | (bus.newDataAvailible && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (bus.newDataAvailible) begin
                    ic_d     = bus.Iin;
                    qc_d     = bus.Qin;
                    ip_d     = hist_i_q;
                    qp_d     = hist_q_q;
                    hist_i_d = bus.Iin;
                    hist_q_d = bus.Qin;
                    state_d  = ST_MULT;
                end
            end
            ST_MULT: begin
                p_rr_d  = deq_mul(ip_q, ic_q);
                p_qq_d  = deq_nmul(qp_q, qc_q);
                p_iq_d  = deq_mul(ip_q, qc_q);
                p_qi_d  = deq_nmul(qp_q, ic_q);
                state_d = ST_SUM;
            end
            ST_SUM: begin
                r_d     = p_rr_q - p_qq_q;
                i_d     = p_iq_q + p_qi_q;
                state_d = ST_PREP;
            end
            ST_PREP: begin
                x_neg_d   = r_q < 0;
                y_neg_d   = i_q < 0;
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_ANGLE;
                end
            end
            ST_ANGLE: begin
                angle_d = y_neg_q ? -mag_a : mag_a;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                dout_d  = DATA_WIDTH'(deq(64'(GAIN) * 64'(angle_q), BITS));
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ic_q      <= '0;
            qc_q      <= '0;
            ip_q      <= '0;
            qp_q      <= '0;
            hist_i_q  <= '0;
            hist_q_q  <= '0;
            p_rr_q    <= '0;
            p_qq_q    <= '0;
            p_iq_q    <= '0;
            p_qi_q    <= '0;
            r_q       <= '0;
            i_q       <= '0;
            x_neg_q   <= 1'b0;
            y_neg_q   <= 1'b0;
            angle_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ic_q      <= ic_d;
            qc_q      <= qc_d;
            ip_q      <= ip_d;
            qp_q      <= qp_d;
            hist_i_q  <= hist_i_d;
            hist_q_q  <= hist_q_d;
            p_rr_q    <= p_rr_d;
            p_qq_q    <= p_qq_d;
            p_iq_q    <= p_iq_d;
            p_qi_q    <= p_qi_d;
            r_q       <= r_d;
            i_q       <= i_d;
            x_neg_q   <= x_neg_d;
            y_neg_q   <= y_neg_d;
            angle_q   <= angle_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.Dout    = dout_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state_q != ST_IDLE) || done_q;
    assign bus.Overrun = overrun_q;

endmodule

// File: tb/tb_fm_demod.sv
// Self-checking bench for fm_demod: arithmetic/timing model plus directed vectors.
module tb_fm_demod;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fm_demod_if #(.DATA_WIDTH(32)) bus ();

    fm_demod #(.DATA_WIDTH(32), .BITS(10), .GAIN(758)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int strobe_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic discriminator: conjugate product, qarctan, gain.
    function automatic int deq_m(input longint x);
        return int'(x >>> 10);
    endfunction

    function automatic int model_dout(input int ip, input int qp, input int ic, input int qc);
        int r, i, ay, num, den, q, a;
        r  = deq_m(longint'(ip) * ic) - deq_m(-(longint'(qp) * qc));
        i  = deq_m(longint'(ip) * qc) + deq_m(-(longint'(qp) * ic));
        ay = ((i < 0) ? -i : i) + 1;
        if (r >= 0) begin
            num = int'(longint'(r - ay) * 1024);
            den = r + ay;
            a   = 804;
        end else begin
            num = int'(longint'(r + ay) * 1024);
            den = ay - r;
            a   = 2412;
        end
        q = int'(longint'(num) / longint'(den));
        a = a - deq_m(804 * longint'(q));
        if (i < 0) a = -a;
        return deq_m(758 * longint'(a));
    endfunction

    // Timing model: accept when nothing is pending, result 38 edges later.
    int m_ecnt = 0;
    int m_done_edge = 0;
    bit m_inflight = 1'b0;
    bit m_ovr = 1'b0;
    int m_hi = 0;
    int m_hq = 0;
    int m_pend = 0;
    int m_dout = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ecnt      <= 0;
            m_done_edge <= 0;
            m_inflight  <= 1'b0;
            m_ovr       <= 1'b0;
            m_hi        <= 0;
            m_hq        <= 0;
            m_pend      <= 0;
            m_dout      <= 0;
        end else begin
            m_ecnt <= m_ecnt + 1;
            if (m_inflight && (m_ecnt + 1 == m_done_edge)) m_dout <= m_pend;
            if (bus.newDataAvailible) begin
                if (!m_inflight || (m_ecnt + 1 > m_done_edge)) begin
                    m_inflight  <= 1'b1;
                    m_done_edge <= m_ecnt + 1 + 38;
                    m_pend      <= model_dout(m_hi, m_hq, bus.Iin, bus.Qin);
                    m_hi        <= bus.Iin;
                    m_hq        <= bus.Qin;
                end else begin
                    m_ovr <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("done", bus.Done, longint'(m_inflight && (m_ecnt == m_done_edge)));
        check("busy", bus.Busy, longint'(m_inflight && (m_ecnt <= m_done_edge)));
        check("overrun", bus.Overrun, longint'(m_ovr));
        check("dout", bus.Dout, m_dout);
    end

    task automatic send(input int i_val, input int q_val, input bit record);
        bus.Iin = i_val;
        bus.Qin = q_val;
        bus.newDataAvailible = 1'b1;
        @(posedge clock);
        #1;
        if (record) strobe_cyc = cyc;
        #1 bus.newDataAvailible = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp);
        int n;
        n = 0;
        @(negedge clock);
        while (bus.Done !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (bus.Done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: Done not seen within 60 cycles", name);
        end else begin
            check({name, "_latency"}, cyc - strobe_cyc, 38);
            check({name, "_dout"}, bus.Dout, exp);
        end
    endtask

    task automatic count_done(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (bus.Done === 1'b1) seen++;
        end
        check(name, seen, 0);
    endtask

    int vi[4] = '{123456, -50000, -2000000, 7};
    int vq[4] = '{-98765, 70000, -3000000, 3};
    int pv_i = 0;
    int pv_q = 0;

    initial begin
        bus.Iin = '0;
        bus.Qin = '0;
        bus.newDataAvailible = 1'b0;

        check("pin_zero", model_dout(0, 0, 0, 0), 1190);
        check("pin_same", model_dout(1024, 0, 1024, 0), 1);
        check("pin_plus90", model_dout(1024, 0, 0, 1024), 1190);
        check("pin_minus90", model_dout(1024, 0, 0, -1024), -1191);

        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_dout", bus.Dout, 0);
        check("rst_done", bus.Done, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_overrun", bus.Overrun, 0);

        send(0, 0, 1'b1);
        wait_done("zero_first", 1190);

        send(1024, 0, 1'b1);
        wait_done("step_a", 1190);
        send(1024, 0, 1'b1);              // exactly 39 cycles after the previous strobe
        wait_done("same_phase", 1);
        check("spacing39_overrun", bus.Overrun, 0);

        send(0, 1024, 1'b1);
        wait_done("plus90", 1190);
        send(1024, 0, 1'b1);
        wait_done("back_from_q", -1191);
        send(0, -1024, 1'b1);
        wait_done("minus90", -1191);

        send(1024, 0, 1'b1);
        repeat (9) @(posedge clock);
        #2;
        send(5000, 7000, 1'b0);
        wait_done("overrun_first", 1190);
        check("overrun_set", bus.Overrun, 1);
        count_done("single_done", 45);
        send(1024, 0, 1'b1);
        wait_done("hist_kept", 1);
        check("overrun_sticky", bus.Overrun, 1);

        send(3000, -2000, 1'b1);
        repeat (20) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        check("abort_overrun", bus.Overrun, 0);
        check("abort_dout", bus.Dout, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        count_done("abort_no_done", 45);
        send(0, 0, 1'b1);
        wait_done("after_reset", 1190);

        for (int k = 0; k < 4; k++) begin
            send(vi[k], vq[k], 1'b1);
            wait_done($sformatf("vec%0d", k), model_dout(pv_i, pv_q, vi[k], vq[k]));
            pv_i = vi[k];
            pv_q = vq[k];
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
